// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_pkg
//  Description : Shared definitions for the two-requester ALU arbiter:
//                6-bit ALU opcode constants, the arbiter FSM state encoding
//                and the opcode classification helpers.
//  Contents    : c_ALU_* opcode constants, arb_state_t, op_is_legal(),
//                op_is_slt()
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // ALU opcodes (6 bits)
    localparam logic [5:0] c_ALU_ADD  = 6'h20;
    localparam logic [5:0] c_ALU_ADDU = 6'h21;
    localparam logic [5:0] c_ALU_SUB  = 6'h22;
    localparam logic [5:0] c_ALU_SUBU = 6'h23;
    localparam logic [5:0] c_ALU_AND  = 6'h24;
    localparam logic [5:0] c_ALU_OR   = 6'h25;
    localparam logic [5:0] c_ALU_XOR  = 6'h26;
    localparam logic [5:0] c_ALU_NOR  = 6'h27;
    localparam logic [5:0] c_ALU_SLT  = 6'h2A;
    localparam logic [5:0] c_ALU_SLTU = 6'h2B;
    localparam logic [5:0] c_ALU_SLL  = 6'h00;
    localparam logic [5:0] c_ALU_SRL  = 6'h02;
    localparam logic [5:0] c_ALU_SRA  = 6'h03;
    localparam logic [5:0] c_ALU_SLLV = 6'h04;
    localparam logic [5:0] c_ALU_SRLV = 6'h06;
    localparam logic [5:0] c_ALU_SRAV = 6'h07;
    localparam logic [5:0] c_ALU_LUI  = 6'h0F;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // True for every opcode the attached ALU implements
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            c_ALU_ADD, c_ALU_ADDU, c_ALU_SUB, c_ALU_SUBU,
            c_ALU_AND, c_ALU_OR,   c_ALU_XOR, c_ALU_NOR,
            c_ALU_SLT, c_ALU_SLTU,
            c_ALU_SLL, c_ALU_SRL,  c_ALU_SRA,
            c_ALU_SLLV, c_ALU_SRLV, c_ALU_SRAV,
            c_ALU_LUI: legal = 1'b1;
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Only the set-less-than opcodes forward the ALU flag to the response
    function automatic logic op_is_slt(input logic [5:0] op);
        return (op == c_ALU_SLT) || (op == c_ALU_SLTU);
    endfunction

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pick
//  Description : Two-way grant selection. A lone valid requester always
//                wins; when both are valid the pointer selects the winner.
//  Ports       : valid[1:0] - request valid per requester
//                ptr        - preferred requester on a tie
//                grant[1:0] - one-hot grant (zero when nothing is valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arb_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule : alu_arb_pick
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one external 32-bit ALU between two requesters.
//                One operation is in flight at a time: IDLE grants and
//                registers a request, EXEC presents it to the ALU for one
//                cycle and captures the result, RESP holds the response
//                until the granted requester accepts it.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                req_valid/req_ready - per-requester request handshake
//                req_aluc/req_a/req_b- packed per-requester opcode/operands
//                alu_a/alu_b/alu_aluc- drive to the shared ALU
//                alu_r/alu_zero/alu_flag - ALU result inputs
//                rsp_valid/rsp_ready - per-requester response handshake
//                rsp_r/rsp_zero/rsp_flag/rsp_err - shared response payload
//  Config      : ALU_ARBITER_RR_EN - defined: round-robin tie break,
//                undefined: fixed priority (requester 0 wins ties)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [11:0]     req_aluc,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [5:0]      alu_aluc,
    input  logic [DW-1:0]   alu_r,
    input  logic            alu_zero,
    input  logic            alu_flag,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [DW-1:0]   rsp_r,
    output logic            rsp_zero,
    output logic            rsp_flag,
    output logic            rsp_err
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;

    logic [1:0]      w_grant;
    logic            w_gidx;
    logic            w_ptr;
    logic            w_accept;

    logic [5:0]      r_aluc;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic            r_gidx;

    logic [DW-1:0]   r_rsp_r;
    logic            r_rsp_zero;
    logic            r_rsp_flag;
    logic            r_rsp_err;

    // ------------------------------------------------------------------
    // Tie-break pointer
    // ------------------------------------------------------------------
`ifdef ALU_ARBITER_RR_EN
    logic r_rr_ptr;

    // After a grant the other requester becomes preferred
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_gidx;
        end
    end

    assign w_ptr = r_rr_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    alu_arb_pick u_pick (
        .valid (req_valid),
        .ptr   (w_ptr),
        .grant (w_grant)
    );

    assign w_gidx   = w_grant[1];
    assign w_accept = (r_state == ST_IDLE) && (|w_grant);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_grant)          w_state_nxt = ST_EXEC;
            ST_EXEC:                        w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready[r_gidx]) w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        alu_a     = '0;
        alu_b     = '0;
        alu_aluc  = 6'd0;
        case (r_state)
            // Ready is masked during reset so nothing is accepted that cycle
            ST_IDLE: if (!rst) req_ready = w_grant;
            ST_EXEC: begin
                alu_a    = r_a;
                alu_b    = r_b;
                alu_aluc = r_aluc;
            end
            ST_RESP: begin
                alu_a     = r_a;
                alu_b     = r_b;
                alu_aluc  = r_aluc;
                rsp_valid = r_gidx ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluc     <= 6'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_gidx     <= 1'b0;
            r_rsp_r    <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_flag <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_aluc <= w_gidx ? req_aluc[11:6]     : req_aluc[5:0];
                r_a    <= w_gidx ? req_a[2*DW-1:DW]   : req_a[DW-1:0];
                r_b    <= w_gidx ? req_b[2*DW-1:DW]   : req_b[DW-1:0];
                r_gidx <= w_gidx;
            end
            // The ALU result is sampled on the last edge of EXEC
            if (r_state == ST_EXEC) begin
                if (op_is_legal(r_aluc)) begin
                    r_rsp_r    <= alu_r;
                    r_rsp_zero <= alu_zero;
                    r_rsp_flag <= op_is_slt(r_aluc) & alu_flag;
                    r_rsp_err  <= 1'b0;
                end else begin
                    r_rsp_r    <= '0;
                    r_rsp_zero <= 1'b0;
                    r_rsp_flag <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
            end
        end
    end

    assign rsp_r    = r_rsp_r;
    assign rsp_zero = r_rsp_zero;
    assign rsp_flag = r_rsp_flag;
    assign rsp_err  = r_rsp_err;

endmodule : alu_arbiter
`default_nettype wire
